// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI arbiter: FSM encoding, owner ids
// and the AXI burst/response constants used around it.
package ysyx_23060025_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } arb_state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060025_rr_arb2.sv
// Two-way round-robin picker: bit 0 is the IFU, bit 1 the LSU. On a conflict
// the side that did not win last time is granted; a lone request wins at once.
module ysyx_23060025_rr_arb2
    import ysyx_23060025_axi_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == OWNER_LSU) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= OWNER_LSU;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Single-outstanding AXI arbiter merging IFU reads and LSU reads/writes onto
// one downstream master port toward the xbar.
module ysyx_23060025_axi_arbiter
    import ysyx_23060025_axi_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_ar_valid,
    output logic                ifu_ar_ready,
    input  logic [ADDR_LEN-1:0] ifu_ar_addr,
    input  logic [7:0]          ifu_ar_len,
    input  logic [2:0]          ifu_ar_size,
    output logic                ifu_r_valid,
    input  logic                ifu_r_ready,
    output logic [DATA_LEN-1:0] ifu_r_data,
    output logic [1:0]          ifu_r_resp,
    output logic                ifu_r_last,

    input  logic                lsu_ar_valid,
    output logic                lsu_ar_ready,
    input  logic [ADDR_LEN-1:0] lsu_ar_addr,
    input  logic [7:0]          lsu_ar_len,
    input  logic [2:0]          lsu_ar_size,
    output logic                lsu_r_valid,
    input  logic                lsu_r_ready,
    output logic [DATA_LEN-1:0] lsu_r_data,
    output logic [1:0]          lsu_r_resp,
    output logic                lsu_r_last,

    input  logic                lsu_aw_valid,
    output logic                lsu_aw_ready,
    input  logic [ADDR_LEN-1:0] lsu_aw_addr,
    input  logic [7:0]          lsu_aw_len,
    input  logic [2:0]          lsu_aw_size,
    input  logic                lsu_w_valid,
    output logic                lsu_w_ready,
    input  logic [DATA_LEN-1:0] lsu_w_data,
    input  logic [3:0]          lsu_w_strb,
    input  logic                lsu_w_last,
    output logic                lsu_b_valid,
    input  logic                lsu_b_ready,
    output logic [1:0]          lsu_b_resp,

    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ADDR_LEN-1:0] m_ar_addr,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [DATA_LEN-1:0] m_r_data,
    input  logic [1:0]          m_r_resp,
    input  logic                m_r_last,

    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_LEN-1:0] m_aw_addr,
    output logic [7:0]          m_aw_len,
    output logic [2:0]          m_aw_size,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_LEN-1:0] m_w_data,
    output logic [3:0]          m_w_strb,
    output logic                m_w_last,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [1:0]          m_b_resp,

    output logic                busy,
    output logic                owner_lsu,
    output logic                err,
    output logic [2:0]          dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and the arbiter only forwards ready
    // from the side that currently owns the channel.

    arb_state_e          state, state_nxt;
    logic [ADDR_LEN-1:0] addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic                err_q;
    logic [1:0]          req, grant;
    logic                last_grant;
    logic                idle, rd_data, wr_data, wr_resp;
    logic                grant_ifu, grant_lsu_rd, grant_lsu_wr;

    assign idle    = (state == ST_IDLE);
    assign rd_data = (state == ST_RD_DATA);
    assign wr_data = (state == ST_WR_DATA);
    assign wr_resp = (state == ST_WR_RESP);

    // A pending LSU write shadows a pending LSU read.
    assign req = {lsu_aw_valid | lsu_ar_valid, ifu_ar_valid};

    ysyx_23060025_rr_arb2 u_rr_arb2 (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .update     (idle),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign grant_ifu    = idle & grant[0];
    assign grant_lsu_wr = idle & grant[1] & lsu_aw_valid;
    assign grant_lsu_rd = idle & grant[1] & ~lsu_aw_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (grant_lsu_wr) begin
                    state_nxt = ST_WR_ADDR;
                end else if (grant_ifu || grant_lsu_rd) begin
                    state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (m_ar_ready) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (m_r_valid && m_r_ready && m_r_last) state_nxt = ST_IDLE;
            ST_WR_ADDR: if (m_aw_ready) state_nxt = ST_WR_DATA;
            ST_WR_DATA: if (lsu_w_valid && m_w_ready && lsu_w_last) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (m_b_valid && lsu_b_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
        end else if (grant_ifu) begin
            addr_q <= ifu_ar_addr;
            len_q  <= ifu_ar_len;
            size_q <= ifu_ar_size;
        end else if (grant_lsu_rd) begin
            addr_q <= lsu_ar_addr;
            len_q  <= lsu_ar_len;
            size_q <= lsu_ar_size;
        end else if (grant_lsu_wr) begin
            addr_q <= lsu_aw_addr;
            len_q  <= lsu_aw_len;
            size_q <= lsu_aw_size;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((m_r_valid && m_r_ready && resp_is_err(m_r_resp)) ||
                     (m_b_valid && m_b_ready && resp_is_err(m_b_resp))) begin
            err_q <= 1'b1;
        end
    end

    assign ifu_ar_ready = grant_ifu;
    assign lsu_ar_ready = grant_lsu_rd;
    assign lsu_aw_ready = grant_lsu_wr;

    assign m_ar_valid = (state == ST_RD_ADDR);
    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_size  = size_q;
    assign m_aw_valid = (state == ST_WR_ADDR);
    assign m_aw_addr  = addr_q;
    assign m_aw_len   = len_q;
    assign m_aw_size  = size_q;

    // Read data goes to whichever side won the grant for this transaction.
    assign m_r_ready   = rd_data & ((last_grant == OWNER_LSU) ? lsu_r_ready : ifu_r_ready);
    assign ifu_r_valid = rd_data & (last_grant == OWNER_IFU) & m_r_valid;
    assign lsu_r_valid = rd_data & (last_grant == OWNER_LSU) & m_r_valid;
    assign ifu_r_data  = m_r_data;
    assign ifu_r_resp  = m_r_resp;
    assign ifu_r_last  = m_r_last;
    assign lsu_r_data  = m_r_data;
    assign lsu_r_resp  = m_r_resp;
    assign lsu_r_last  = m_r_last;

    assign m_w_valid   = wr_data & lsu_w_valid;
    assign lsu_w_ready = wr_data & m_w_ready;
    assign m_w_data    = lsu_w_data;
    assign m_w_strb    = lsu_w_strb;
    assign m_w_last    = lsu_w_last;

    assign lsu_b_valid = wr_resp & m_b_valid;
    assign m_b_ready   = wr_resp & lsu_b_ready;
    assign lsu_b_resp  = m_b_resp;

    assign busy      = ~idle;
    assign owner_lsu = last_grant;
    assign err       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: directed scenarios followed by random
// rounds, with the bench acting as requesters and as the downstream slave.
module tb_ysyx_23060025_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          ifu_ar_valid, ifu_ar_ready;
    logic [AW-1:0] ifu_ar_addr;
    logic [7:0]    ifu_ar_len;
    logic [2:0]    ifu_ar_size;
    logic          ifu_r_valid, ifu_r_ready, ifu_r_last;
    logic [DW-1:0] ifu_r_data;
    logic [1:0]    ifu_r_resp;
    logic          lsu_ar_valid, lsu_ar_ready;
    logic [AW-1:0] lsu_ar_addr;
    logic [7:0]    lsu_ar_len;
    logic [2:0]    lsu_ar_size;
    logic          lsu_r_valid, lsu_r_ready, lsu_r_last;
    logic [DW-1:0] lsu_r_data;
    logic [1:0]    lsu_r_resp;
    logic          lsu_aw_valid, lsu_aw_ready;
    logic [AW-1:0] lsu_aw_addr;
    logic [7:0]    lsu_aw_len;
    logic [2:0]    lsu_aw_size;
    logic          lsu_w_valid, lsu_w_ready, lsu_w_last;
    logic [DW-1:0] lsu_w_data;
    logic [3:0]    lsu_w_strb;
    logic          lsu_b_valid, lsu_b_ready;
    logic [1:0]    lsu_b_resp;
    logic          m_ar_valid, m_ar_ready;
    logic [AW-1:0] m_ar_addr;
    logic [7:0]    m_ar_len;
    logic [2:0]    m_ar_size;
    logic          m_r_valid, m_r_ready, m_r_last;
    logic [DW-1:0] m_r_data;
    logic [1:0]    m_r_resp;
    logic          m_aw_valid, m_aw_ready;
    logic [AW-1:0] m_aw_addr;
    logic [7:0]    m_aw_len;
    logic [2:0]    m_aw_size;
    logic          m_w_valid, m_w_ready, m_w_last;
    logic [DW-1:0] m_w_data;
    logic [3:0]    m_w_strb;
    logic          m_b_valid, m_b_ready;
    logic [1:0]    m_b_resp;
    logic          busy, owner_lsu, err;
    logic [2:0]    dbg_state;

    ysyx_23060025_axi_arbiter #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clock(clock), .reset(reset),
        .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
        .ifu_ar_len(ifu_ar_len), .ifu_ar_size(ifu_ar_size),
        .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data),
        .ifu_r_resp(ifu_r_resp), .ifu_r_last(ifu_r_last),
        .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
        .lsu_ar_len(lsu_ar_len), .lsu_ar_size(lsu_ar_size),
        .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data),
        .lsu_r_resp(lsu_r_resp), .lsu_r_last(lsu_r_last),
        .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
        .lsu_aw_len(lsu_aw_len), .lsu_aw_size(lsu_aw_size),
        .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data),
        .lsu_w_strb(lsu_w_strb), .lsu_w_last(lsu_w_last),
        .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
        .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
        .busy(busy), .owner_lsu(owner_lsu), .err(err), .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending requests (0 = IFU read, 1 = LSU read,
    // 2 = LSU write), who won last, and the sticky error flag.
    bit            p_pend[3];
    logic [AW-1:0] p_addr[3];
    logic [7:0]    p_len[3];
    logic [2:0]    p_size[3];
    bit            last_lsu;
    bit            err_exp;
    logic [DW-1:0] exp_q[$];

    int            force_stall = -1;
    int            force_resp  = -1;
    bit            force_data_en = 1'b0;
    logic [DW-1:0] force_data = '0;
    bit            abort_rd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req();
        ifu_ar_valid = p_pend[0]; ifu_ar_addr = p_addr[0]; ifu_ar_len = p_len[0]; ifu_ar_size = p_size[0];
        lsu_ar_valid = p_pend[1]; lsu_ar_addr = p_addr[1]; lsu_ar_len = p_len[1]; lsu_ar_size = p_size[1];
        lsu_aw_valid = p_pend[2]; lsu_aw_addr = p_addr[2]; lsu_aw_len = p_len[2]; lsu_aw_size = p_size[2];
    endtask

    task automatic new_req(input int k, input logic [AW-1:0] addr, input logic [7:0] len);
        p_pend[k] = 1'b1;
        p_addr[k] = addr;
        p_len[k]  = len;
        p_size[k] = 3'($urandom_range(0, 2));
    endtask

    task automatic clear_slave();
        m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0;
        m_r_valid = 0; m_r_data = '0; m_r_resp = 0; m_r_last = 0;
        m_b_valid = 0; m_b_resp = 0;
        ifu_r_ready = 0; lsu_r_ready = 0; lsu_b_ready = 0;
        lsu_w_valid = 0; lsu_w_data = '0; lsu_w_strb = 0; lsu_w_last = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            p_pend[k] = 0; p_addr[k] = '0; p_len[k] = 0; p_size[k] = 0;
        end
        last_lsu = 1'b1;
        err_exp  = 1'b0;
        exp_q.delete();
    endtask

    // One complete transaction, starting in an IDLE cycle and ending in the
    // IDLE cycle that follows it.
    task automatic do_round();
        int            win, stall, beats, cnt, guard, other;
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [2:0]    s;
        logic          exp_owner, cur_valid, rdy, wv, mr, bv, done;
        logic [DW-1:0] cur_data, wd;
        logic [1:0]    cur_resp;
        logic [3:0]    ws;

        drive_req();
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_err", err, err_exp);
        chk("idle_m_ar_valid", m_ar_valid, 0);
        chk("idle_m_aw_valid", m_aw_valid, 0);
        if (p_pend[0] && (p_pend[1] || p_pend[2])) win = last_lsu ? 0 : (p_pend[2] ? 2 : 1);
        else if (p_pend[0]) win = 0;
        else win = p_pend[2] ? 2 : 1;
        chk("grant_ifu_ar", ifu_ar_ready, win == 0);
        chk("grant_lsu_ar", lsu_ar_ready, win == 1);
        chk("grant_lsu_aw", lsu_aw_ready, win == 2);
        last_lsu  = (win != 0);
        exp_owner = last_lsu;
        a = p_addr[win]; l = p_len[win]; s = p_size[win];
        p_pend[win] = 1'b0;
        beats = int'(l) + 1;

        tick();
        stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) tick();
            drive_req();
            m_ar_ready = (win != 2) && (i == stall);
            m_aw_ready = (win == 2) && (i == stall);
            m_w_ready  = 1'b1;
            #1;
            chk("addr_busy", busy, 1);
            chk("addr_owner", owner_lsu, exp_owner);
            chk("addr_m_ar_valid", m_ar_valid, win != 2);
            chk("addr_m_aw_valid", m_aw_valid, win == 2);
            chk("addr_value", (win == 2) ? m_aw_addr : m_ar_addr, a);
            chk("addr_len", (win == 2) ? m_aw_len : m_ar_len, l);
            chk("addr_size", (win == 2) ? m_aw_size : m_ar_size, s);
            chk("addr_no_regrant", {ifu_ar_ready, lsu_ar_ready, lsu_aw_ready}, 0);
            chk("addr_w_ready", lsu_w_ready, 0);
        end

        if (win != 2) begin
            cnt = 0; guard = 0; cur_valid = 0; cur_data = '0; cur_resp = 0;
            while (cnt < beats) begin
                tick();
                m_ar_ready = 0; m_w_ready = 0;
                if (!cur_valid && ($urandom_range(0, 2) != 0)) begin
                    cur_valid = 1'b1;
                    cur_data  = force_data_en ? force_data : $urandom;
                    cur_resp  = (force_resp >= 0) ? 2'(force_resp)
                              : (($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
                    exp_q.push_back(cur_data);
                end
                m_r_valid = cur_valid; m_r_data = cur_data; m_r_resp = cur_resp;
                m_r_last  = (cnt == beats - 1);
                rdy   = ($urandom_range(0, 3) != 0);
                other = int'($urandom_range(0, 1));
                if (win == 0) begin ifu_r_ready = rdy; lsu_r_ready = other[0]; end
                else begin lsu_r_ready = rdy; ifu_r_ready = other[0]; end
                #1;
                if (abort_rd && cur_valid) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_busy", busy, 0);
                    chk("abort_ifu_r_valid", ifu_r_valid, 0);
                    chk("abort_lsu_r_valid", lsu_r_valid, 0);
                    chk("abort_m_r_ready", m_r_ready, 0);
                    chk("abort_m_ar_valid", m_ar_valid, 0);
                    chk("abort_owner", owner_lsu, 1);
                    chk("abort_state", dbg_state, 0);
                    tick();
                    reset = 1'b0;
                    model_reset();
                    clear_slave();
                    drive_req();
                    return;
                end
                chk("r_valid_owner", (win == 0) ? ifu_r_valid : lsu_r_valid, cur_valid);
                chk("r_valid_other", (win == 0) ? lsu_r_valid : ifu_r_valid, 0);
                chk("r_m_ready", m_r_ready, rdy);
                chk("r_w_ready", lsu_w_ready, 0);
                if (cur_valid) begin
                    chk("r_data", (win == 0) ? ifu_r_data : lsu_r_data, exp_q[0]);
                    chk("r_resp", (win == 0) ? ifu_r_resp : lsu_r_resp, cur_resp);
                    chk("r_last", (win == 0) ? ifu_r_last : lsu_r_last, cnt == beats - 1);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        cnt++;
                        cur_valid = 1'b0;
                        if (cur_resp != 2'b00) err_exp = 1'b1;
                    end
                end
                guard++;
                if (guard > 400) begin
                    chk("r_timeout", 1, 0);
                    break;
                end
            end
        end else begin
            cnt = 0; guard = 0;
            while (cnt < beats) begin
                tick();
                m_aw_ready = 0;
                wv = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 3) != 0);
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
                lsu_w_valid = wv; lsu_w_data = wd; lsu_w_strb = ws;
                lsu_w_last  = (cnt == beats - 1);
                m_w_ready   = mr;
                #1;
                chk("w_m_valid", m_w_valid, wv);
                chk("w_lsu_ready", lsu_w_ready, mr);
                if (wv) begin
                    chk("w_data", m_w_data, wd);
                    chk("w_strb", m_w_strb, ws);
                    chk("w_last", m_w_last, cnt == beats - 1);
                    if (mr) cnt++;
                end
                guard++;
                if (guard > 400) begin
                    chk("w_timeout", 1, 0);
                    break;
                end
            end
            done = 0; guard = 0;
            while (!done) begin
                tick();
                lsu_w_valid = 0; lsu_w_last = 0; m_w_ready = 1'b1;
                bv  = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 3) != 0);
                cur_resp = (force_resp >= 0) ? 2'(force_resp)
                         : (($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
                m_b_valid = bv; m_b_resp = cur_resp; lsu_b_ready = rdy;
                #1;
                chk("b_valid", lsu_b_valid, bv);
                chk("b_m_ready", m_b_ready, rdy);
                chk("b_w_ready", lsu_w_ready, 0);
                if (bv) chk("b_resp", lsu_b_resp, cur_resp);
                if (bv && rdy) begin
                    done = 1'b1;
                    if (cur_resp != 2'b00) err_exp = 1'b1;
                end
                guard++;
                if (guard > 400) begin
                    chk("b_timeout", 1, 0);
                    break;
                end
            end
        end
        tick();
        clear_slave();
    endtask

    initial begin
        model_reset();
        clear_slave();
        drive_req();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_owner", owner_lsu, 1);
        chk("rst_state", dbg_state, 0);
        chk("rst_valids", {m_ar_valid, m_aw_valid, m_w_valid, ifu_r_valid, lsu_r_valid, lsu_b_valid}, 0);
        chk("rst_readies", {ifu_ar_ready, lsu_ar_ready, lsu_aw_ready, lsu_w_ready, m_r_ready, m_b_ready}, 0);
        chk("rst_latch", {m_ar_addr, m_ar_len, m_ar_size}, 0);
        reset = 1'b0;

        // IFU wins the first conflict after reset, then the LSU, then the IFU.
        new_req(0, 32'h8000_0000, 8'd1);
        new_req(1, 32'h8000_1000, 8'd0);
        do_round();
        do_round();
        new_req(0, 32'h8000_0010, 8'd0);
        new_req(1, 32'h8000_1010, 8'd2);
        do_round();
        do_round();

        // Lone IFU read with a fixed data word and no slave stall.
        force_data_en = 1'b1; force_data = 32'hDEAD_BEEF; force_resp = 0; force_stall = 0;
        new_req(0, 32'h3000_0000, 8'd0);
        do_round();
        force_data_en = 1'b0; force_resp = -1; force_stall = -1;

        // Write beats read: 4-beat write first, then the LSU read.
        new_req(2, 32'h8000_2000, 8'd3);
        new_req(1, 32'h8000_3000, 8'd0);
        do_round();
        do_round();

        // Five-cycle AR stall with the other requester waiting.
        force_stall = 5;
        new_req(0, 32'h8000_4000, 8'd0);
        new_req(1, 32'h8000_5000, 8'd1);
        do_round();
        force_stall = -1;
        do_round();

        // SLVERR read makes err sticky through later OKAY traffic.
        force_resp = 2;
        new_req(0, 32'h8000_6000, 8'd0);
        do_round();
        force_resp = 0;
        new_req(1, 32'h8000_7000, 8'd1);
        do_round();
        new_req(2, 32'h8000_8000, 8'd0);
        do_round();
        force_resp = -1;

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 3; k++) begin
                if (!p_pend[k] && ($urandom_range(0, 1) != 0))
                    new_req(k, $urandom, 8'($urandom_range(0, 3)));
            end
            if (!p_pend[0] && !p_pend[1] && !p_pend[2])
                new_req(int'($urandom_range(0, 2)), $urandom, 8'($urandom_range(0, 3)));
            do_round();
        end

        // Reset while a read beat is pending, then a clean transaction.
        for (int k = 0; k < 3; k++) p_pend[k] = 1'b0;
        abort_rd = 1'b1;
        new_req(0, 32'h9000_0000, 8'd1);
        do_round();
        abort_rd = 1'b0;
        chk("post_abort_err", err, 0);
        force_resp = 0;
        new_req(0, 32'h9000_0100, 8'd0);
        new_req(1, 32'h9000_0200, 8'd0);
        do_round();
        do_round();
        force_resp = -1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
